// File: rtl/apb_req_arbiter.sv
// apb_req_arbiter: round-robin multi-requester APB master.
//
// Takes transfer requests from NREQ requesters and serves them one at a time,
// using a round-robin pointer. Each granted transfer runs the APB SETUP/ACCESS
// sequence toward one of NSLV slaves. The slave is decoded from address bits
// starting at SEL_LSB. An optional pready timeout aborts an ACCESS phase that
// never completes.
//
// Ports
//   pclk, presetn          clock, async active-low reset
//   req/req_write          per-requester request and direction
//   req_addr/req_wdata     per-requester address / write data (32 bits each)
//   done                   one-cycle completion pulse to the granted requester
//   rsp_rdata/rsp_err      response, valid while any done bit is high
//   psel/penable/pwrite    APB control toward the slaves
//   paddr/pwdata           APB address / write data
//   prdata/pready/pslverr  per-slave APB responses
module apb_req_arbiter #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned NSLV    = 4,
    parameter int unsigned SEL_LSB = 10,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                 pclk,
    input  logic                 presetn,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      req_write,
    input  logic [NREQ*32-1:0]   req_addr,
    input  logic [NREQ*32-1:0]   req_wdata,
    output logic [NREQ-1:0]      done,
    output logic [31:0]          rsp_rdata,
    output logic                 rsp_err,
    output logic [NSLV-1:0]      psel,
    output logic                 penable,
    output logic                 pwrite,
    output logic [31:0]          paddr,
    output logic [31:0]          pwdata,
    input  logic [NSLV*32-1:0]   prdata,
    input  logic [NSLV-1:0]      pready,
    input  logic [NSLV-1:0]      pslverr
);

    localparam int unsigned RW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned SW = (NSLV > 1) ? $clog2(NSLV) : 1;
    localparam int unsigned TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {StIdle, StSetup, StAccess, StResp} state_e;

    state_e         state_q, state_d;
    logic [RW-1:0]  rr_q, rr_d;
    logic [RW-1:0]  grant_q, grant_d;
    logic           pwrite_q, pwrite_d;
    logic [31:0]    paddr_q, paddr_d;
    logic [31:0]    pwdata_q, pwdata_d;
    logic [SW-1:0]  slv_q, slv_d;
    logic [31:0]    rdata_q, rdata_d;
    logic           err_q, err_d;
    logic [TW-1:0]  tmo_q, tmo_d;

    // Requester index 'off' positions after 'base', wrapping modulo NREQ.
    function automatic logic [RW-1:0] rr_idx(logic [RW-1:0] base, int unsigned off);
        return RW'((32'(base) + off) % NREQ);
    endfunction

    // Round-robin pick and the picked requester's fields.
    logic           found;
    logic [RW-1:0]  pick;
    logic           new_write;
    logic [31:0]    new_addr;
    logic [31:0]    new_wdata;
    logic [SW-1:0]  new_sel;
    logic           dec_err;

    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (!found && req[rr_idx(rr_q, i)]) begin
                found = 1'b1;
                pick  = rr_idx(rr_q, i);
            end
        end
        new_write = 1'b0;
        new_addr  = '0;
        new_wdata = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (pick == RW'(i)) begin
                new_write = req_write[i];
                new_addr  = req_addr[32*i +: 32];
                new_wdata = req_wdata[32*i +: 32];
            end
        end
        new_sel = new_addr[SEL_LSB +: SW];
        // Select field can encode more slaves than exist when NSLV is not a power of two.
        dec_err = (32'(new_sel) >= NSLV);
    end

    // Response mux from the currently selected slave.
    logic           sel_ready;
    logic           sel_err;
    logic [31:0]    sel_rdata;

    always_comb begin
        sel_ready = 1'b0;
        sel_err   = 1'b0;
        sel_rdata = '0;
        for (int unsigned s = 0; s < NSLV; s++) begin
            if (slv_q == SW'(s)) begin
                sel_ready = pready[s];
                sel_err   = pslverr[s];
                sel_rdata = prdata[32*s +: 32];
            end
        end
    end

    // State register.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q  <= StIdle;
            rr_q     <= '0;
            grant_q  <= '0;
            pwrite_q <= 1'b0;
            paddr_q  <= '0;
            pwdata_q <= '0;
            slv_q    <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            tmo_q    <= '0;
        end else begin
            state_q  <= state_d;
            rr_q     <= rr_d;
            grant_q  <= grant_d;
            pwrite_q <= pwrite_d;
            paddr_q  <= paddr_d;
            pwdata_q <= pwdata_d;
            slv_q    <= slv_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            tmo_q    <= tmo_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d  = state_q;
        rr_d     = rr_q;
        grant_d  = grant_q;
        pwrite_d = pwrite_q;
        paddr_d  = paddr_q;
        pwdata_d = pwdata_q;
        slv_d    = slv_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        tmo_d    = tmo_q;
        unique case (state_q)
            StIdle: begin
                if (found) begin
                    grant_d  = pick;
                    pwrite_d = new_write;
                    paddr_d  = new_addr;
                    pwdata_d = new_wdata;
                    slv_d    = new_sel;
                    if (dec_err) begin
                        rdata_d = '0;
                        err_d   = 1'b1;
                        state_d = StResp;
                    end else begin
                        state_d = StSetup;
                    end
                end
            end
            StSetup: begin
                tmo_d   = '0;
                state_d = StAccess;
            end
            StAccess: begin
                if (sel_ready) begin
                    rdata_d = pwrite_q ? 32'h0 : sel_rdata;
                    err_d   = sel_err;
                    state_d = StResp;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                    // Abort on the TIMEOUT-th ACCESS cycle that saw no ready.
                    if (TIMEOUT != 0 && (32'(tmo_q) + 32'd1 == TIMEOUT)) begin
                        rdata_d = '0;
                        err_d   = 1'b1;
                        state_d = StResp;
                    end
                end
            end
            StResp: begin
                rr_d    = rr_idx(grant_q, 1);
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs; psel/penable/done decode from state so reset clears them at once.
    always_comb begin
        psel    = '0;
        penable = 1'b0;
        done    = '0;
        unique case (state_q)
            StSetup, StAccess: begin
                for (int unsigned s = 0; s < NSLV; s++) begin
                    psel[s] = (slv_q == SW'(s));
                end
                penable = (state_q == StAccess);
            end
            StResp: begin
                for (int unsigned i = 0; i < NREQ; i++) begin
                    done[i] = (grant_q == RW'(i));
                end
            end
            default: ;
        endcase
    end

    assign pwrite    = pwrite_q;
    assign paddr     = paddr_q;
    assign pwdata    = pwdata_q;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule

// File: doc/apb_req_arbiter.md
# apb_req_arbiter

Multi-requester APB master for the single-master/multi-slave APB subsystem. It accepts transfer requests from `NREQ` independent requesters and arbitrates among them round-robin. It runs the APB SETUP/ACCESS protocol toward `NSLV` slave memories, decodes the slave from address bits, and returns read data, completion and error status to the granted requester. It guards each access with an optional pready timeout.

## Interface
- `NREQ`, 4, number of requesters (2..8)
- `NSLV`, 4, number of APB slaves (1..8)
- `SEL_LSB`, 10, LSB of slave-select field in address; field is `paddr[SEL_LSB +: $clog2(NSLV)]` (min width 1)
- `TIMEOUT`, 16, max ACCESS cycles waiting for pready; 0 = no timeout

Ports:
- `pclk`  in  1  clock; all logic on rising edge
- `presetn`  in  1  asynchronous active-low reset
- `req`  in  NREQ  per-requester transfer request, held until `done[i]`
- `req_write`  in  NREQ  per-requester direction (1 = write)
- `req_addr`  in  NREQ*32  per-requester address, slice i = `[32*i +: 32]`
- `req_wdata`  in  NREQ*32  per-requester write data
- `done`  out  NREQ  one-cycle completion pulse to granted requester
- `rsp_rdata`  out  32  read data, valid while any `done` bit is high
- `rsp_err`  out  1  error status, valid while any `done` bit is high
- `psel`  out  NSLV  one-hot slave select
- `penable`  out  1  APB enable
- `pwrite`  out  1  APB direction
- `paddr`  out  32  APB address (full requester address, unmodified)
- `pwdata`  out  32  APB write data
- `prdata`  in  NSLV*32  per-slave read data
- `pready`  in  NSLV  per-slave ready
- `pslverr`  in  NSLV  per-slave error

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE: if any `req` is high, grant the first requester at or after the RR pointer, wrapping modulo NREQ. Register that requester's write, address and wdata into the APB outputs. If the decoded slave index is ≥ NSLV, go to RESP with err = 1 and drive no psel. Otherwise go to SETUP.
- SETUP: `psel[s]` = 1 and `penable` = 0 for exactly one cycle, then ACCESS.
- ACCESS: `psel[s]` = 1 and `penable` = 1. Hold until `pready[s]`.
  - On `pready[s]`: capture `prdata[s]` (reads only; writes return 0) and `pslverr[s]` into the response registers, then go to RESP.
- Timeout: a counter clears on entry to ACCESS and increments each ACCESS cycle with `pready[s]` = 0. If TIMEOUT > 0 and the count reaches TIMEOUT, abort to RESP with err = 1 and rdata = 0. A pready arriving on that same cycle wins: normal completion.
- RESP: all psel = 0 and `penable` = 0. `done[grant]` = 1 for one cycle with `rsp_rdata`/`rsp_err`. RR pointer = grant+1 mod NREQ. Next state is IDLE.
- The requester must deassert `req` (or present a new transfer) at the edge ending the RESP cycle. `req` seen in IDLE is always treated as a new request.
- Only the granted requester's fields are sampled, and only in IDLE. Later changes to `req_*` have no effect on the transfer in flight.
- A requester dropping `req` after grant does not abort the transfer.

## Timing
- Reset (async, immediate): state = IDLE, RR pointer = 0, timeout counter = 0. Outputs `psel`, `penable`, `pwrite`, `paddr`, `pwdata`, `done`, `rsp_rdata`, `rsp_err` all 0.
- Reset asserted mid-transfer drops psel/penable combinationally with presetn. No `done` is issued for the aborted transfer.
- Zero-wait slave: request seen in IDLE at cycle 0 → SETUP cycle 1 → ACCESS cycle 2 → `done` cycle 3. Four cycles per transfer including IDLE.
- Each wait state adds one ACCESS cycle.
- Back-to-back transfers always pass through IDLE. Both `penable` and `psel` are low for at least 2 cycles (RESP + IDLE) between transfers.
- Decode error: IDLE → RESP. `done` follows request sampling by exactly one cycle, and the APB bus is untouched.
- Timeout: `done` with err = 1 in the cycle after the TIMEOUT-th ACCESS cycle without ready.
- The APB outputs `pwrite`/`paddr`/`pwdata` are stable from SETUP through the last ACCESS cycle.

## Test plan
- Single write then read, slave 0 zero-wait: write addr 0x0000_0004 data 0xDEAD_BEEF, then read the same address. Required: psel = 0001, `done` on cycle 3 of each transfer, `rsp_rdata` = 0xDEAD_BEEF, `rsp_err` = 0.
- Arbitration, NREQ = 4: all four requesters assert `req` together targeting slaves 0..3, each held until its own `done`. Required: grants in order 0, 1, 2, 3. Requester 0 re-requesting after its `done` is served only after requester 3.
- Wait states: a slave that raises pready on the 3rd ACCESS cycle (2 wait states). Required: ACCESS lasts 3 cycles, `done` at cycle 5, and `paddr`/`pwdata` stable throughout.
- Timeout, TIMEOUT = 4: slave `pready` held 0. Required: 4 ACCESS cycles, then `done` with `rsp_err` = 1 and `rsp_rdata` = 0. Next request served normally.
- Decode error, NSLV = 3: request to addr 0x0000_0C00 (select = 3). Required: no psel asserted, `done` one cycle after IDLE sampling, `rsp_err` = 1.
- Reset mid-access: drop `presetn` during ACCESS. Required: psel/penable go to 0 immediately, and no `done` is issued. After reset release, a pending `req` from requester 2 is granted via pointer 0 scan.
